// File: rtl/select_scan.sv
// Clocked CH-to-1 data selector with manual (sel) and scan (dwell sequencer) modes.
// Optional per-channel scan mask enabled by defining SELECT_SCAN_MASK_EN.
module select_scan #(
  parameter int unsigned CH    = 8,
  parameter int unsigned W     = 1,
  parameter int unsigned SW    = $clog2(CH),
  parameter int unsigned DWELL = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  input  logic [CH*W-1:0] Din,
`ifdef SELECT_SCAN_MASK_EN
  input  logic [CH-1:0]   mask,
`endif
  output logic [W-1:0]    Dout,
  output logic [SW-1:0]   chan,
  output logic            valid,
  output logic            wrap
);

  localparam int unsigned CW = $clog2(DWELL + 1);

  typedef enum logic [1:0] {S_IDLE, S_MANUAL, S_SCAN} state_t;

  state_t        r_state;
  logic [W-1:0]  r_dout;
  logic [SW-1:0] r_chan;
  logic          r_valid;
  logic          r_wrap;
  logic [CW-1:0] r_cnt;

  logic [W-1:0]  w_ch [CH];
  logic          w_sel_ok;
  logic          w_last;
  logic          w_any;
  logic [SW-1:0] w_first;
  logic [SW-1:0] w_next;
  logic          w_wrap;

  // Unpack the flat channel bus so channels can be indexed directly.
  for (genvar g = 0; g < int'(CH); g++) begin : g_ch
    assign w_ch[g] = Din[g*W +: W];
  end

  // Sequencer look-ahead: next channel, first channel and roll-over flag.
  always_comb begin
    w_sel_ok = (32'(sel) < CH);
    w_last   = (r_cnt == CW'(DWELL - 1));
`ifdef SELECT_SCAN_MASK_EN
    w_any    = |mask;
    w_first  = '0;
    w_next   = '0;
    for (int i = int'(CH) - 1; i >= 0; i--) begin
      if (mask[i]) begin
        w_first = SW'(i);
      end
    end
    w_next = w_first;
    for (int i = int'(CH) - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(r_chan))) begin
        w_next = SW'(i);
      end
    end
    w_wrap   = (w_next <= r_chan);
`else
    w_any    = 1'b1;
    w_first  = '0;
    w_next   = (r_chan == SW'(CH - 1)) ? '0 : r_chan + SW'(1);
    w_wrap   = (r_chan == SW'(CH - 1));
`endif
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_dout  <= '0;
      r_chan  <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_wrap <= 1'b0;
      if (!enable) begin
        r_state <= S_IDLE;
        r_dout  <= '0;
        r_chan  <= '0;
        r_valid <= 1'b0;
        r_cnt   <= '0;
      end else if (!mode) begin
        r_state <= S_MANUAL;
        r_cnt   <= '0;
        r_chan  <= sel;
        r_valid <= w_sel_ok;
        r_dout  <= w_sel_ok ? w_ch[sel] : '0;
      end else if ((r_state != S_SCAN) || (!r_valid && w_any)) begin
        // Scan entry, or resume after an all-zero mask.
        r_state <= S_SCAN;
        r_cnt   <= '0;
        r_chan  <= w_first;
        r_valid <= w_any;
        r_dout  <= w_any ? w_ch[w_first] : '0;
      end else if (!w_any) begin
        r_dout  <= '0;
        r_valid <= 1'b0;
        r_cnt   <= '0;
      end else if (w_last) begin
        r_cnt   <= '0;
        r_chan  <= w_next;
        r_dout  <= w_ch[w_next];
        r_wrap  <= w_wrap;
      end else begin
        r_cnt   <= r_cnt + CW'(1);
        r_dout  <= w_ch[r_chan];
      end
    end
  end

  assign Dout  = r_dout;
  assign chan  = r_chan;
  assign valid = r_valid;
  assign wrap  = r_wrap;

endmodule
